// File: rtl/btn_sw_pkg.sv
// rtl/btn_sw_pkg.sv - shared constants and types for btn_sw_debounce
package btn_sw_pkg;

    localparam int DB_CYCLES_DEF     = 500000;
    localparam int REPEAT_DELAY_DEF  = 25000000;
    localparam int REPEAT_CYCLES_DEF = 10000000;

    localparam int SW_GUESS_IDX = 4;
    localparam int SW_TURN_IDX  = 5;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

endpackage

// File: rtl/db_cell.sv
// rtl/db_cell.sv - single-bit synchroniser, debounce counter and edge pulses
module db_cell
    import btn_sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_level_nxt,
    output logic o_rise_nxt,
    output logic o_fall_nxt
);

    localparam int              CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_q;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    db_state_t     r_state;

    logic w_s;
    logic w_accept;

    assign w_s      = r_sync[1];
    assign w_accept = (r_state == COUNT) && (w_s != r_q) && (r_cnt == TERM);

    // Next-state views let the top register derived outputs in the same cycle as the level.
    always_comb begin
        o_level_nxt = r_q;
        o_rise_nxt  = 1'b0;
        o_fall_nxt  = 1'b0;
        if (w_accept) begin
            o_level_nxt = w_s;
            o_rise_nxt  = w_s;
            o_fall_nxt  = ~w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
            r_state <= STABLE;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_q    <= o_level_nxt;
            r_rise <= o_rise_nxt;
            r_fall <= o_fall_nxt;
            case (r_state)
                STABLE: begin
                    if (w_s != r_q) begin
                        r_state <= COUNT;
                        r_cnt   <= CW'(1);
                    end
                end
                COUNT: begin
                    if (w_s == r_q || r_cnt == TERM) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = r_q;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/btn_sw_debounce.sv
// rtl/btn_sw_debounce.sv - button/switch conditioning; BTN_SW_DEBOUNCE_AUTOREPEAT_EN adds button auto-repeat
module btn_sw_debounce
    import btn_sw_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int N_SW          = 6,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_single,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_rise,
    output logic [N_SW-1:0]  sw_fall,
    output logic             guess_commit
);

    logic [N_BTN-1:0] w_btn_rise;
    logic [N_BTN-1:0] w_btn_fall;
    logic [N_BTN-1:0] w_btn_lvl_nxt;
    logic [N_BTN-1:0] w_btn_rise_nxt;
    logic [N_BTN-1:0] w_btn_fall_nxt;
    logic [N_SW-1:0]  w_sw_lvl_nxt;
    logic [N_SW-1:0]  w_sw_rise_nxt;
    logic [N_SW-1:0]  w_sw_fall_nxt;
    logic [N_BTN-1:0] w_rep_nxt;
    logic [N_BTN-1:0] w_press_nxt;
    logic [N_BTN-1:0] w_single_nxt;

    logic [N_BTN-1:0] r_btn_press;
    logic [N_BTN-1:0] r_btn_single;
    logic             r_guess_commit;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        db_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_raw       (btn_raw[gi]),
            .o_level     (btn_level[gi]),
            .o_rise      (w_btn_rise[gi]),
            .o_fall      (w_btn_fall[gi]),
            .o_level_nxt (w_btn_lvl_nxt[gi]),
            .o_rise_nxt  (w_btn_rise_nxt[gi]),
            .o_fall_nxt  (w_btn_fall_nxt[gi])
        );
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        db_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_raw       (sw_raw[gi]),
            .o_level     (sw_level[gi]),
            .o_rise      (sw_rise[gi]),
            .o_fall      (sw_fall[gi]),
            .o_level_nxt (w_sw_lvl_nxt[gi]),
            .o_rise_nxt  (w_sw_rise_nxt[gi]),
            .o_fall_nxt  (w_sw_fall_nxt[gi])
        );
    end

`ifdef BTN_SW_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_CYCLES);

    logic [N_BTN-1:0][RW-1:0] r_rep_cnt;
    logic [N_BTN-1:0]         r_rep_armed;

    // r_rep_cnt holds cycles since the last press or repeat; armed selects the shorter period.
    always_comb begin
        w_rep_nxt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rep_nxt[i] = btn_level[i] & w_btn_lvl_nxt[i] &
                           (r_rep_cnt[i] == (r_rep_armed[i] ? REP_NEXT : REP_FIRST));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!w_btn_lvl_nxt[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_armed[i] <= 1'b0;
                end else if (w_btn_rise_nxt[i]) begin
                    r_rep_cnt[i]   <= RW'(1);
                    r_rep_armed[i] <= 1'b0;
                end else if (w_rep_nxt[i]) begin
                    r_rep_cnt[i]   <= RW'(1);
                    r_rep_armed[i] <= 1'b1;
                end else if (r_rep_cnt[i] != '0) begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    logic w_unused_rep_cfg;
    assign w_unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_CYCLES};
    assign w_rep_nxt        = '0;
`endif

    always_comb begin
        w_press_nxt  = w_btn_rise_nxt | w_rep_nxt;
        w_single_nxt = '0;
        if ($countones(w_btn_lvl_nxt) == 1 && |w_press_nxt) begin
            w_single_nxt = w_press_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_press    <= '0;
            r_btn_single   <= '0;
            r_guess_commit <= 1'b0;
        end else begin
            r_btn_press    <= w_press_nxt;
            r_btn_single   <= w_single_nxt;
            r_guess_commit <= w_sw_fall_nxt[SW_GUESS_IDX];
        end
    end

    assign btn_press    = r_btn_press;
    assign btn_single   = r_btn_single;
    assign guess_commit = r_guess_commit;

    logic w_unused_sigs;
    assign w_unused_sigs = ^{w_btn_rise, w_btn_fall, w_btn_fall_nxt,
                             w_sw_lvl_nxt, w_sw_rise_nxt, w_sw_fall_nxt};

endmodule
